// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared funct3 encodings, FSM state type and width constant for
//            the MEM-stage load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RMW  = 1'b1
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage_if
// Brief    : Pipeline request/response and data_mem bus of the MEM-stage LSU.
//            master = pipeline + memory side, slave = the LSU itself.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_stage_if #(
  parameter int XLEN = 32
);
  logic            mem_read;
  logic            mem_write;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] load_data;
  logic            stall;
  logic            misaligned;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic            dm_we;
  logic            dm_re;
  logic [XLEN-1:0] dm_rdata;

  modport master (
    output mem_read, mem_write, funct3, addr, store_data, dm_rdata,
    input  load_data, stall, misaligned, dm_addr, dm_wdata, dm_we, dm_re
  );

  modport slave (
    input  mem_read, mem_write, funct3, addr, store_data, dm_rdata,
    output load_data, stall, misaligned, dm_addr, dm_wdata, dm_we, dm_re
  );
endinterface
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Brief    : Combinational byte/half lane select with sign or zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = lsu_pkg::XLEN
) (
  input  logic [XLEN-1:0] dm_rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte    = dm_rdata[{addr, 3'b000} +: 8];
    // Halfword lane ignores addr[0]; misaligned halves are handled upstream.
    w_half    = dm_rdata[{addr[1], 4'b0000} +: 16];
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_H:    load_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, w_half};
      F3_W:    load_data = dm_rdata;
      default: load_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage
// Brief    : MEM-stage load/store unit: word-addressed data_mem access,
//            sub-word loads by lane select, SB/SH by two-cycle read-modify-
//            write. Optional macro LSU_MISALIGN_TRAP_EN blocks misaligned
//            accesses and raises misaligned.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int XLEN = lsu_pkg::XLEN
) (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_stage_if.slave bus
);

  lsu_state_t      r_state;
  lsu_state_t      w_state_nxt;
  logic [XLEN-1:0] r_merge_q;
  logic [XLEN-1:0] r_addr_q;

  logic [XLEN-1:0] w_word_addr;
  logic [XLEN-1:0] w_merge;
  logic [XLEN-1:0] w_load_aligned;
  logic [XLEN-1:0] w_dm_addr;
  logic [XLEN-1:0] w_dm_wdata;
  logic            w_store_ok;
  logic            w_load_ok;
  logic            w_trap;
  logic            w_load_en;
  logic            w_rmw_start;
  logic            w_we;
  logic            w_re;
  logic            w_stall;

  assign w_word_addr = {bus.addr[XLEN-1:2], 2'b00};

  // A store wins over a simultaneous load.
  assign w_store_ok = bus.mem_write && (bus.funct3 inside {F3_B, F3_H, F3_W});
  assign w_load_ok  = bus.mem_read && !bus.mem_write &&
                      (bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_mis_cond;

  always_comb begin
    w_mis_cond = 1'b0;
    if (w_store_ok || w_load_ok) begin
      case (bus.funct3)
        F3_H, F3_HU: w_mis_cond = bus.addr[0];
        F3_W:        w_mis_cond = (bus.addr[1:0] != 2'b00);
        default:     w_mis_cond = 1'b0;
      endcase
    end
  end

  assign w_trap = w_mis_cond && (r_state == IDLE);
`else
  assign w_trap = 1'b0;
`endif

  // Read word with the target byte or half replaced by the store lane(s).
  always_comb begin
    w_merge = bus.dm_rdata;
    if (bus.funct3 == F3_H) begin
      w_merge[{bus.addr[1], 4'b0000} +: 16] = bus.store_data[15:0];
    end else begin
      w_merge[{bus.addr[1:0], 3'b000} +: 8] = bus.store_data[7:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dm_addr   = w_word_addr;
    w_dm_wdata  = '0;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_stall     = 1'b0;
    w_load_en   = 1'b0;
    w_rmw_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_trap) begin
          if (w_store_ok) begin
            if (bus.funct3 == F3_W) begin
              w_we       = 1'b1;
              w_dm_wdata = bus.store_data;
            end else begin
              w_re        = 1'b1;
              w_stall     = 1'b1;
              w_rmw_start = 1'b1;
              w_state_nxt = RMW;
            end
          end else if (w_load_ok) begin
            w_re      = 1'b1;
            w_load_en = 1'b1;
          end
        end
      end
      RMW: begin
        // Pipeline inputs are held by the previous stall and not looked at.
        w_we        = 1'b1;
        w_dm_addr   = r_addr_q;
        w_dm_wdata  = r_merge_q;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_merge_q <= '0;
      r_addr_q  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rmw_start) begin
        r_merge_q <= w_merge;
        r_addr_q  <= w_word_addr;
      end
    end
  end

  lsu_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .dm_rdata  (bus.dm_rdata),
    .addr      (bus.addr[1:0]),
    .funct3    (bus.funct3),
    .load_data (w_load_aligned)
  );

  // Reset masks the strobes so a write pending in RMW is dropped.
  assign bus.dm_addr    = w_dm_addr;
  assign bus.dm_wdata   = w_dm_wdata;
  assign bus.dm_we      = w_we && !rst;
  assign bus.dm_re      = w_re && !rst;
  assign bus.stall      = w_stall && !rst;
  assign bus.misaligned = w_trap && !rst;
  assign bus.load_data  = (w_load_en && !rst) ? w_load_aligned : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_stage
// Brief    : Self-checking bench: directed vector table, reset-during-RMW
//            sequence and random traffic against a byte-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic preload;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lsu_mem_stage_if #(.XLEN(32)) bus ();

  lsu_mem_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Word-addressed data_mem: combinational read, write on the rising edge.
  logic [31:0] mem [0:63];
  assign bus.dm_rdata = mem[bus.dm_addr[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
    end else if (bus.dm_we) begin
      mem[bus.dm_addr[7:2]] <= bus.dm_wdata;
    end
  end

  // Reference memory as individual bytes, little-endian.
  logic [7:0] bm [0:255];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_ld;
    logic        exp_st;
    logic        exp_mis;
    logic        exp_re;
    logic        exp_we;
    logic        ck_addr;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic model_eval(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, output logic [31:0] ld,
                            output logic st, output logic mis,
                            output logic re, output logic we);
    int b, hb, wb;
    logic st_ok, ld_ok, mc;
    b     = int'(a[7:0]);
    hb    = b - (b % 2);
    wb    = b - (b % 4);
    st_ok = wr && (f3 <= 3'd2);
    ld_ok = rd && !wr && (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mc    = 1'b0;
    if ((st_ok || ld_ok) && f3[1:0] == 2'b01) mc = a[0];
    if ((st_ok || ld_ok) && f3 == 3'd2)       mc = (a[1:0] != 2'b00);
    mis = TRAP && mc;
    ld  = '0;
    st  = 1'b0;
    re  = 1'b0;
    we  = 1'b0;
    if (!mis) begin
      st = st_ok && (f3 != 3'd2);
      we = st_ok && (f3 == 3'd2);
      re = st || ld_ok;
      if (ld_ok) begin
        case (f3)
          3'd0: ld = 32'($signed(bm[b]));
          3'd4: ld = 32'(bm[b]);
          3'd1: ld = 32'($signed({bm[hb+1], bm[hb]}));
          3'd5: ld = 32'({bm[hb+1], bm[hb]});
          default: ld = {bm[wb+3], bm[wb+2], bm[wb+1], bm[wb]};
        endcase
      end
    end
  endtask

  task automatic model_commit(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ld;
    logic st, mis, re, we;
    int b, hb, wb;
    model_eval(rd, wr, f3, a, ld, st, mis, re, we);
    b  = int'(a[7:0]);
    hb = b - (b % 2);
    wb = b - (b % 4);
    if (st && f3 == 3'd0) bm[b] = d[7:0];
    if (st && f3 == 3'd1) begin
      bm[hb]   = d[7:0];
      bm[hb+1] = d[15:8];
    end
    if (we) begin
      bm[wb]   = d[7:0];
      bm[wb+1] = d[15:8];
      bm[wb+2] = d[23:16];
      bm[wb+3] = d[31:24];
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends the access.
  task automatic apply(input string nm, input vec_t v);
    bus.mem_read   = v.rd;
    bus.mem_write  = v.wr;
    bus.funct3     = v.f3;
    bus.addr       = v.a;
    bus.store_data = v.d;
    #2;
    chk({nm, ".load_data"}, bus.load_data, v.exp_ld);
    chk({nm, ".stall"}, 32'(bus.stall), 32'(v.exp_st));
    chk({nm, ".misaligned"}, 32'(bus.misaligned), 32'(v.exp_mis));
    chk({nm, ".dm_re"}, 32'(bus.dm_re), 32'(v.exp_re));
    chk({nm, ".dm_we"}, 32'(bus.dm_we), 32'(v.exp_we));
    if (v.ck_addr) chk({nm, ".dm_addr"}, bus.dm_addr, {v.a[31:2], 2'b00});
    @(posedge clk); #1;
    if (v.exp_st) begin
      #1;
      chk({nm, ".rmw_stall"}, 32'(bus.stall), 32'd0);
      chk({nm, ".rmw_we"}, 32'(bus.dm_we), 32'd1);
      chk({nm, ".rmw_addr"}, bus.dm_addr, {v.a[31:2], 2'b00});
      @(posedge clk); #1;
    end
    model_commit(v.rd, v.wr, v.f3, v.a, v.d);
  endtask

  task automatic idle_inputs();
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.funct3     = 3'd0;
    bus.addr       = '0;
    bus.store_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [31:0] ld;
    logic st, mis, re, we;
    int r;

    for (int w = 0; w < 64; w++) begin
      bm[4*w]   = 8'(w);
      bm[4*w+1] = 8'h00;
      bm[4*w+2] = 8'h00;
      bm[4*w+3] = 8'h00;
    end

    // ---------------- reset state ----------------
    idle_inputs();
    rst     = 1'b1;
    preload = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.stall", 32'(bus.stall), 32'd0);
    chk("rst.dm_we", 32'(bus.dm_we), 32'd0);
    chk("rst.dm_re", 32'(bus.dm_re), 32'd0);
    chk("rst.misaligned", 32'(bus.misaligned), 32'd0);
    chk("rst.load_data", bus.load_data, 32'd0);
    bus.mem_write = 1'b1;
    bus.addr      = 32'h9;
    #1;
    chk("rst.sb_stall", 32'(bus.stall), 32'd0);
    idle_inputs();
    preload = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ---------------- directed vector table ----------------
    //                rd wr f3    addr       data           load_data      st mis re we ck
    vt.push_back(vec_t'{1, 0, 3'd2, 32'h14, 32'h0,         32'h00000005, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{0, 1, 3'd0, 32'h09, 32'h000000AB,  32'h0,        1, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd0, 32'h09, 32'h0,         32'hFFFFFFAB, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd4, 32'h09, 32'h0,         32'h000000AB, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd1, 32'h08, 32'h0,         32'hFFFFAB02, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd5, 32'h08, 32'h0,         32'h0000AB02, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd2, 32'h08, 32'h0,         32'h0000AB02, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{0, 1, 3'd1, 32'h0E, 32'hFFFF1234,  32'h0,        1, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd1, 32'h0E, 32'h0,         32'h00001234, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd2, 32'h0C, 32'h0,         32'h12340003, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{0, 1, 3'd0, 32'h10, 32'h00000011,  32'h0,        1, 0, 1, 0, 1});
    vt.push_back(vec_t'{0, 1, 3'd0, 32'h13, 32'h00000044,  32'h0,        1, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd2, 32'h10, 32'h0,         32'h44000011, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 1, 3'd2, 32'h18, 32'hCAFEBABE,  32'h0,        0, 0, 0, 1, 1});
    vt.push_back(vec_t'{1, 0, 3'd2, 32'h18, 32'h0,         32'hCAFEBABE, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd0, 32'h1B, 32'h0,         32'hFFFFFFCA, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd4, 32'h1A, 32'h0,         32'h000000FE, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd3, 32'h04, 32'h0,         32'h0,        0, 0, 0, 0, 0});
    vt.push_back(vec_t'{0, 1, 3'd7, 32'h04, 32'h12345678,  32'h0,        0, 0, 0, 0, 0});
    vt.push_back(vec_t'{0, 0, 3'd2, 32'h04, 32'h0,         32'h0,        0, 0, 0, 0, 0});
`ifdef LSU_MISALIGN_TRAP_EN
    vt.push_back(vec_t'{1, 0, 3'd2, 32'h06, 32'h0,         32'h0,        0, 1, 0, 0, 0});
    vt.push_back(vec_t'{0, 1, 3'd2, 32'h06, 32'h0000DEAD,  32'h0,        0, 1, 0, 0, 0});
    vt.push_back(vec_t'{1, 0, 3'd2, 32'h04, 32'h0,         32'h00000001, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd1, 32'h0F, 32'h0,         32'h0,        0, 1, 0, 0, 0});
    vt.push_back(vec_t'{0, 1, 3'd1, 32'h0F, 32'h00005678,  32'h0,        0, 1, 0, 0, 0});
    vt.push_back(vec_t'{1, 0, 3'd2, 32'h0C, 32'h0,         32'h12340003, 0, 0, 1, 0, 1});
`else
    vt.push_back(vec_t'{1, 0, 3'd2, 32'h06, 32'h0,         32'h00000001, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{0, 1, 3'd2, 32'h06, 32'h0000DEAD,  32'h0,        0, 0, 0, 1, 1});
    vt.push_back(vec_t'{1, 0, 3'd2, 32'h04, 32'h0,         32'h0000DEAD, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd1, 32'h0F, 32'h0,         32'h00001234, 0, 0, 1, 0, 1});
    vt.push_back(vec_t'{0, 1, 3'd1, 32'h0F, 32'h00005678,  32'h0,        1, 0, 1, 0, 1});
    vt.push_back(vec_t'{1, 0, 3'd2, 32'h0C, 32'h0,         32'h56780003, 0, 0, 1, 0, 1});
`endif

    foreach (vt[i]) apply($sformatf("vec%0d", i), vt[i]);
    idle_inputs();
    @(posedge clk); #1;

    // ---------------- reset during the RMW cycle of SB 0x00 ----------------
    bus.mem_write  = 1'b1;
    bus.funct3     = 3'd0;
    bus.addr       = 32'h0;
    bus.store_data = 32'h000000FF;
    #1;
    chk("rstrmw.stall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstrmw.we_masked", 32'(bus.dm_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("rstrmw.stall_after", 32'(bus.stall), 32'd0);
    chk("rstrmw.we_after", 32'(bus.dm_we), 32'd0);
    chk("rstrmw.word0", mem[0], 32'h0);
    @(posedge clk); #1;
    v = vec_t'{1, 0, 3'd2, 32'h00, 32'h0, 32'h0, 0, 0, 1, 0, 1};
    apply("rstrmw.lw0", v);

    // ---------------- random traffic against the model ----------------
    for (int n = 0; n < 400; n++) begin
      r      = $urandom_range(0, 9);
      v.a    = 32'($urandom_range(0, 255));
      v.d    = $urandom;
      v.rd   = 1'b0;
      v.wr   = 1'b0;
      v.f3   = 3'($urandom_range(0, 7));
      if (r <= 4) begin
        v.rd = 1'b1;
      end else if (r <= 7) begin
        v.wr = 1'b1;
        v.f3 = 3'($urandom_range(0, 2));
      end else if (r == 8) begin
        v.rd = 1'b1;
        v.wr = 1'b1;
        v.f3 = 3'($urandom_range(0, 2));
      end else begin
        v.wr = 1'b1;
        v.f3 = (v.f3[0]) ? 3'd3 : 3'd6 + 3'(v.f3[1]);
      end
      model_eval(v.rd, v.wr, v.f3, v.a, ld, st, mis, re, we);
      v.exp_ld  = ld;
      v.exp_st  = st;
      v.exp_mis = mis;
      v.exp_re  = re;
      v.exp_we  = we;
      v.ck_addr = re || we;
      apply($sformatf("rand%0d", n), v);
    end
    idle_inputs();
    @(posedge clk); #1;

    // ---------------- final memory image ----------------
    for (int w = 0; w < 64; w++) begin
      chk($sformatf("mem[%0d]", w), mem[w], {bm[4*w+3], bm[4*w+2], bm[4*w+1], bm[4*w]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the MEM pipeline stage, placed between the EX/MEM pipeline register and the word-addressed `data_mem`. It converts RISC-V load/store funct3 semantics into word accesses. Sub-word loads are served by lane selection and extension. Sub-word stores (SB/SH) use a two-cycle read-modify-write and raise a one-cycle stall. The aligned load/sign-extend result goes to the MEM/WB register.

## Interface
Parameters:
- `XLEN`, default 32, data and address width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `mem_read` in 1: load request from EX/MEM.
- `mem_write` in 1: store request from EX/MEM.
- `funct3` in 3: access size and sign (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010).
- `addr` in 32: byte address.
- `store_data` in 32: rs2 value; low byte/half is used for SB/SH.
- `load_data` out 32: extended load result (combinational).
- `stall` out 1: freeze IF/ID/EX and EX/MEM this cycle.
- `misaligned` out 1: misaligned access flag.
- `dm_addr` out 32: address to `data_mem`, word-aligned (`[1:0]`=0).
- `dm_wdata` out 32: write word to `data_mem`.
- `dm_we` out 1: `data_mem` write enable.
- `dm_re` out 1: `data_mem` read enable.
- `dm_rdata` in 32: `data_mem` combinational read data.

## Operation
- FSM states: IDLE, RMW. Reset enters IDLE.
- **IDLE, load** (`mem_read` and not `mem_write`):
  - `dm_re`=1, `dm_addr`={addr[31:2],2'b00}.
  - Lane = addr[1:0].
  - LB/LBU: sign/zero-extend byte `dm_rdata[8*lane+:8]`.
  - LH/LHU: sign/zero-extend half `dm_rdata[16*addr[1]+:16]`.
  - LW: pass through.
- **IDLE, SW**: `dm_we`=1, `dm_wdata`=`store_data`. No stall.
- **IDLE, SB/SH**:
  - `dm_re`=1, `stall`=1.
  - Register the merged word into `merge_q`: `dm_rdata` with the target lane(s) replaced by `store_data[7:0]` or `store_data[15:0]`.
  - Register the word address into `addr_q`.
  - Next state RMW.
- **RMW**:
  - `dm_we`=1, `dm_addr`=`addr_q`, `dm_wdata`=`merge_q`, `stall`=0.
  - Next state IDLE. The pipeline advances at the end of this cycle.
  - Inputs are ignored in RMW; they are held stable by the prior stall.
- `mem_read` and `mem_write` both high: the store takes priority and the load is ignored.
- Undefined funct3 (011, 110, 111): no `dm_re`/`dm_we`, `load_data`=0, no stall.
- No access in progress: `load_data`=0, `dm_re`=`dm_we`=0.
- `misaligned` conditions: halfword with addr[0]=1; word with addr[1:0]≠0.
- Reset values: state IDLE, `merge_q`=0, `addr_q`=0, `stall`=0, `dm_we`=0, `dm_re`=0, `misaligned`=0.
- Reset mid-RMW: the pending write is dropped and memory is unchanged.

## Timing
- Loads, SW: 0 added cycles. Address to `load_data` is purely combinational through `data_mem`.
- SB/SH: 1 added cycle. `stall` is high for exactly one cycle (the IDLE read cycle), and the write commits on the RMW-cycle rising edge.
- A load immediately following SB/SH (next instruction) sees the updated word, because the write commits before that load reaches MEM.
- Back-to-back SB/SH: each takes 2 cycles. `stall` pattern is 1,0,1,0.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access drives `misaligned`=1 combinationally.
  - `dm_we`=0, `dm_re`=0, no RMW entered, `load_data`=0.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `misaligned` is tied 0.
  - Offending low address bits are ignored (halfword uses addr[1] only; word ignores addr[1:0]) and the access proceeds.

## Structure
- Shared package `lsu_pkg`:
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - State enum `lsu_state_t` {IDLE, RMW}.
  - Helper constant `XLEN`.
- Sub-module `lsu_load_align`: combinational lane select plus sign/zero extension (inputs `dm_rdata`, `addr[1:0]`, `funct3`; output `load_data`).
- The FSM, merge logic and misalignment check live in `lsu_mem_stage`.

## Test plan
Memory is preloaded with word i = i.
- LW `addr`=0x14 → `load_data`=0x00000005, `stall`=0, `dm_addr`=0x14.
- SB `addr`=0x09, `store_data`=0x000000AB → `stall`=1 for one cycle, then word 2 = 0x0000AB02. A following LB 0x09 gives 0xFFFFFFAB; LBU 0x09 gives 0x000000AB.
- SH `addr`=0x0E, `store_data`=0xFFFF1234 → word 3 = 0x12340003. A following LH 0x0E gives 0x00001234.
- Two consecutive SB (0x10 data 0x11, then 0x13 data 0x44) → `stall` 1,0,1,0; word 4 = 0x44000011.
- With the macro defined: LW 0x06 → `misaligned`=1, `load_data`=0. SW 0x06 data 0xDEAD → no write; word 1 remains 1.
- `rst` asserted during the RMW cycle of SB 0x00 data 0xFF → word 0 stays 0x00000000; state IDLE, `stall`=0 after reset.
